// File: rtl/ps2_device_tx_pkg.sv
// Shared types and timing constants for the PS/2 device-side transmitter.
// Also provides the parity and frame-bit helpers used by the send path.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_HIGH = 2'd1,
        ST_SEND      = 2'd2,
        ST_GAP       = 2'd3
    } ps2_state_e;

    localparam int unsigned PHASES_PER_BIT = 8;
    localparam int unsigned HIGH_PHASES    = 4;
    localparam int unsigned QUIET_CYCLES   = 5;
    localparam int unsigned GAP_CYCLES     = 8;
    localparam int unsigned FRAME_BITS     = 11;

    // Counter-width views of the constants above.
    localparam logic [2:0] PHASE_LAST      = 3'(PHASES_PER_BIT - 1);
    localparam logic [2:0] PHASE_CHECK     = 3'(HIGH_PHASES - 1);
    localparam logic [2:0] PHASE_CLK_LOW   = 3'(HIGH_PHASES);
    localparam logic [2:0] QUIET_DONE      = 3'(QUIET_CYCLES);
    localparam logic [2:0] GAP_LAST        = 3'(GAP_CYCLES - 1);
    localparam logic [3:0] BIT_LAST        = 4'(FRAME_BITS - 1);

    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

    // Bit 0 start, 1..8 data LSB first, 9 parity, 10 stop.
    function automatic logic frame_bit(input logic [3:0] idx, input logic [7:0] data,
                                       input logic parity);
        logic value;
        case (idx)
            4'd0:    value = 1'b0;
            4'd9:    value = parity;
            4'd10:   value = 1'b1;
            default: begin
                if ((idx >= 4'd1) && (idx <= 4'd8)) begin
                    value = data[3'(idx - 4'd1)];
                end else begin
                    value = 1'b1;
                end
            end
        endcase
        return value;
    endfunction

endpackage

// File: rtl/ps2_device_tx_if.sv
// Byte handshake and status bundle between a client and the PS/2 transmitter.
interface ps2_device_tx_if;
    logic [7:0] i_data;
    logic       i_valid;
    logic       o_ready;
    logic       o_done;
    logic       o_abort;
    logic       o_host_rts;

    modport master (
        output i_data, i_valid,
        input  o_ready, o_done, o_abort, o_host_rts
    );

    modport slave (
        input  i_data, i_valid,
        output o_ready, o_done, o_abort, o_host_rts
    );
endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one PS/2 bus line; resets to the idle (high) level.
module ps2_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic line,
    output logic synced
);
    logic meta_r;
    logic sync_r;

    // Two-stage capture of the asynchronous line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= 1'b1;
            sync_r <= 1'b1;
        end else begin
            meta_r <= line;
            sync_r <= meta_r;
        end
    end

    assign synced = sync_r;
endmodule

// File: rtl/ps2_device_tx.sv
// PS/2 device-side transmitter: generates PS2_CLK and sends 11-bit frames,
// backing off and retrying whenever the host inhibits the clock mid-frame.
module ps2_device_tx
    import ps2_pkg::*;
(
    input  logic            i_clk_100k,
    input  logic            i_rst,
    ps2_device_tx_if.slave  bus,
    inout  wire             PS2_CLK,
    inout  wire             PS2_DAT
);

    logic       clk_sync_s;
    logic       dat_sync_s;

    ps2_state_e state_r,  state_s;
    logic [3:0] bit_r,    bit_s;
    logic [2:0] phase_r,  phase_s;
    logic [2:0] quiet_r,  quiet_s;
    logic [7:0] data_r,   data_s;
    logic       parity_r, parity_s;
    logic       clk_low_r, clk_low_s;
    logic       dat_low_r, dat_low_s;
    logic       done_r,   done_s;
    logic       abort_r,  abort_s;
    logic       rts_r,    rts_s;
    logic       ready_r,  ready_s;
    logic       accept_s;

    ps2_line_sync u_clk_sync (
        .clk    (i_clk_100k),
        .rst    (i_rst),
        .line   (PS2_CLK),
        .synced (clk_sync_s)
    );

    ps2_line_sync u_dat_sync (
        .clk    (i_clk_100k),
        .rst    (i_rst),
        .line   (PS2_DAT),
        .synced (dat_sync_s)
    );

    assign accept_s = bus.i_valid & ready_r;

    // State, counters, latched byte and all registered outputs.
    always_ff @(posedge i_clk_100k) begin
        if (i_rst) begin
            state_r   <= ST_IDLE;
            bit_r     <= 4'd0;
            phase_r   <= 3'd0;
            quiet_r   <= 3'd0;
            data_r    <= 8'd0;
            parity_r  <= 1'b0;
            clk_low_r <= 1'b0;
            dat_low_r <= 1'b0;
            done_r    <= 1'b0;
            abort_r   <= 1'b0;
            rts_r     <= 1'b0;
            ready_r   <= 1'b1;
        end else begin
            state_r   <= state_s;
            bit_r     <= bit_s;
            phase_r   <= phase_s;
            quiet_r   <= quiet_s;
            data_r    <= data_s;
            parity_r  <= parity_s;
            clk_low_r <= clk_low_s;
            dat_low_r <= dat_low_s;
            done_r    <= done_s;
            abort_r   <= abort_s;
            rts_r     <= rts_s;
            ready_r   <= ready_s;
        end
    end

    // Next-state logic; line drives are derived from the next state so they are registered.
    always_comb begin
        state_s   = state_r;
        bit_s     = bit_r;
        phase_s   = phase_r;
        quiet_s   = quiet_r;
        data_s    = data_r;
        parity_s  = parity_r;
        clk_low_s = 1'b0;
        dat_low_s = 1'b0;
        done_s    = 1'b0;
        abort_s   = 1'b0;
        rts_s     = 1'b0;
        ready_s   = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s  = ST_WAIT_HIGH;
                    data_s   = bus.i_data;
                    parity_s = odd_parity(bus.i_data);
                    quiet_s  = 3'd0;
                    bit_s    = 4'd0;
                    phase_s  = 3'd0;
                end else begin
                    state_s  = ST_IDLE;
                end
            end

            ST_WAIT_HIGH: begin
                if (!clk_sync_s) begin
                    quiet_s = 3'd0;
                end else if (quiet_r == QUIET_DONE) begin
                    state_s = ST_SEND;
                    bit_s   = 4'd0;
                    phase_s = 3'd0;
                    quiet_s = 3'd0;
                end else begin
                    quiet_s = quiet_r + 3'd1;
                end
            end

            ST_SEND: begin
                // Last released phase: a low clock here means the host is inhibiting.
                if ((phase_r == PHASE_CHECK) && (bit_r != BIT_LAST) && !clk_sync_s) begin
                    state_s = ST_WAIT_HIGH;
                    bit_s   = 4'd0;
                    phase_s = 3'd0;
                    quiet_s = 3'd0;
                    abort_s = 1'b1;
                end else if (phase_r == PHASE_LAST) begin
                    phase_s = 3'd0;
                    if (bit_r == BIT_LAST) begin
                        state_s = ST_GAP;
                        bit_s   = 4'd0;
                        quiet_s = 3'd0;
                        done_s  = 1'b1;
                    end else begin
                        bit_s   = bit_r + 4'd1;
                    end
                end else begin
                    phase_s = phase_r + 3'd1;
                end
            end

            ST_GAP: begin
                if (quiet_r == GAP_LAST) begin
                    state_s = ST_IDLE;
                    quiet_s = 3'd0;
                end else begin
                    quiet_s = quiet_r + 3'd1;
                end
            end

            default: begin
                state_s = ST_IDLE;
                bit_s   = 4'd0;
                phase_s = 3'd0;
                quiet_s = 3'd0;
            end
        endcase

        // Data changes only at phase 1; phase 0 keeps the previous bit on the wire.
        if (state_s == ST_SEND) begin
            clk_low_s = (phase_s >= PHASE_CLK_LOW);
            if (phase_s == 3'd0) begin
                dat_low_s = dat_low_r;
            end else begin
                dat_low_s = ~frame_bit(bit_s, data_s, parity_s);
            end
        end else begin
            clk_low_s = 1'b0;
            dat_low_s = 1'b0;
        end

        if (state_s == ST_IDLE) begin
            rts_s   = clk_sync_s & ~dat_sync_s;
            ready_s = ~(clk_sync_s & ~dat_sync_s);
        end else begin
            rts_s   = 1'b0;
            ready_s = 1'b0;
        end
    end

    assign PS2_CLK        = clk_low_r ? 1'b0 : 1'bz;
    assign PS2_DAT        = dat_low_r ? 1'b0 : 1'bz;

    assign bus.o_ready    = ready_r;
    assign bus.o_done     = done_r;
    assign bus.o_abort    = abort_r;
    assign bus.o_host_rts = rts_r;

endmodule

// File: tb/tb_ps2_device_tx.sv
// Self-checking bench for ps2_device_tx: a host-side sampler captures PS2_DAT on
// every PS2_CLK fall and compares whole frames against a queue of expected frames.
module tb_ps2_device_tx;

    logic clk_100k = 1'b0;
    logic rst = 1'b1;
    logic host_clk_low = 1'b0;
    logic host_dat_low = 1'b0;
    wire  ps2_clk;
    wire  ps2_dat;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int abort_cnt = 0;
    int first_fall_cyc = 0;
    int done_cycs[$];
    logic par_log[$];
    logic cap_bits[$];
    logic [10:0] exp_q[$];
    logic [10:0] got_f;
    logic prev_clk = 1'b1;
    logic abort_dat = 1'b0;

    ps2_device_tx_if bus ();

    ps2_device_tx dut (
        .i_clk_100k (clk_100k),
        .i_rst      (rst),
        .bus        (bus),
        .PS2_CLK    (ps2_clk),
        .PS2_DAT    (ps2_dat)
    );

    assign ps2_clk = host_clk_low ? 1'b0 : 1'bz;
    assign ps2_dat = host_dat_low ? 1'b0 : 1'bz;
    pullup (ps2_clk);
    pullup (ps2_dat);

    always #5 clk_100k = ~clk_100k;

    always @(posedge clk_100k) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] model_frame(input logic [7:0] d);
        logic [10:0] f;
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        f[0]   = 1'b0;
        f[8:1] = d;
        f[9]   = ((ones % 2) == 0);
        f[10]  = 1'b1;
        return f;
    endfunction

    // Host-side sampler and scoreboard checker.
    always @(negedge clk_100k) begin
        if (prev_clk === 1'b1 && ps2_clk === 1'b0) begin
            if (cap_bits.size() == 0) first_fall_cyc = cyc;
            cap_bits.push_back(ps2_dat);
        end
        prev_clk = ps2_clk;
        if (bus.o_abort === 1'b1) begin
            abort_cnt++;
            abort_dat = ps2_dat;
            cap_bits.delete();
        end
        if (bus.o_done === 1'b1) begin
            done_cnt++;
            done_cycs.push_back(cyc);
            check_val("frame_len", cap_bits.size(), 11);
            got_f = '1;
            for (int i = 0; i < cap_bits.size() && i < 11; i++) got_f[i] = cap_bits[i];
            par_log.push_back(got_f[9]);
            check_val("sb_has_entry", (exp_q.size() > 0), 1);
            if (exp_q.size() > 0) check_val("frame", got_f, exp_q.pop_front());
            cap_bits.delete();
        end
    end

    task automatic tick();
        @(negedge clk_100k);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, output int n);
        bus.i_data  = b;
        bus.i_valid = 1'b1;
        n = -1;
        for (int k = 0; k < 400 && n < 0; k++) begin
            if (bus.o_ready === 1'b1) begin
                tick();
                n = cyc;
            end else begin
                tick();
            end
        end
        bus.i_valid = 1'b0;
        check_val("accept_in_time", (n >= 0), 1);
        if (n >= 0) exp_q.push_back(model_frame(b));
    endtask

    task automatic wait_done(input int target, input int budget);
        int k;
        k = 0;
        while (done_cnt < target && k < budget) begin
            tick();
            k++;
        end
        check_val("done_in_time", (done_cnt >= target), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int n2;
        int d0;
        int a0;
        int k;

        bus.i_valid = 1'b0;
        bus.i_data  = 8'h00;
        rst = 1'b1;
        repeat (3) tick();
        check_val("rst_ready", bus.o_ready, 1);
        check_val("rst_done", bus.o_done, 0);
        check_val("rst_abort", bus.o_abort, 0);
        check_val("rst_rts", bus.o_host_rts, 0);
        check_val("rst_clk_line", ps2_clk, 1);
        check_val("rst_dat_line", ps2_dat, 1);
        rst = 1'b0;
        tick();
        check_val("idle_ready", bus.o_ready, 1);

        // 0x1C on idle bus: first fall exactly 10 cycles after acceptance.
        send_byte(8'h1C, n);
        wait_done(1, 300);
        check_val("first_fall_1c", first_fall_cyc, n + 10);
        repeat (12) tick();
        check_val("done_once_1c", done_cnt, 1);

        // 0x00 then 0xFF back to back; second accept only after the gap.
        d0 = done_cnt;
        send_byte(8'h00, n);
        send_byte(8'hFF, n2);
        wait_done(d0 + 2, 400);
        if (done_cycs.size() > d0) check_val("gap_spacing", n2, done_cycs[d0] + 9);
        else check_val("gap_spacing_seen", done_cycs.size(), d0 + 1);
        if (par_log.size() >= d0 + 2) begin
            check_val("parity_00", par_log[d0], 1);
            check_val("parity_ff", par_log[d0 + 1], 1);
        end else begin
            check_val("parity_logged", par_log.size(), d0 + 2);
        end

        // Host inhibit during bit 5 phase 2, then full retransmission of 0xF0.
        d0 = done_cnt;
        a0 = abort_cnt;
        send_byte(8'hF0, n);
        k = 0;
        while (cyc < n + 48 && k < 100) begin
            tick();
            k++;
        end
        host_clk_low = 1'b1;
        repeat (20) tick();
        host_clk_low = 1'b0;
        tick();
        check_val("abort_once", abort_cnt, a0 + 1);
        check_val("abort_dat_released", abort_dat, 1);
        check_val("clk_released_after_abort", ps2_clk, 1);
        check_val("no_done_on_abort", done_cnt, d0);
        wait_done(d0 + 1, 300);
        check_val("abort_not_repeated", abort_cnt, a0 + 1);

        // Clock held low before the request: accepted, but no clock until released.
        d0 = done_cnt;
        host_clk_low = 1'b1;
        repeat (4) tick();
        cap_bits.delete();
        send_byte(8'h5A, n);
        repeat (30) tick();
        check_val("no_falls_while_held", cap_bits.size(), 0);
        check_val("dat_idle_while_held", ps2_dat, 1);
        host_clk_low = 1'b0;
        wait_done(d0 + 1, 300);

        // Reset during bit 4 of 0x1C drops the frame silently.
        repeat (12) tick();
        d0 = done_cnt;
        a0 = abort_cnt;
        send_byte(8'h1C, n);
        k = 0;
        while (cap_bits.size() < 5 && k < 200) begin
            tick();
            k++;
        end
        check_val("reached_bit4", cap_bits.size(), 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("rst_mid_clk", ps2_clk, 1);
        check_val("rst_mid_dat", ps2_dat, 1);
        check_val("rst_mid_ready", bus.o_ready, 1);
        exp_q.delete();
        cap_bits.delete();
        repeat (120) tick();
        check_val("rst_mid_no_done", done_cnt, d0);
        check_val("rst_mid_no_abort", abort_cnt, a0);

        // Host request-to-send in idle blocks new frames.
        host_dat_low = 1'b1;
        repeat (5) tick();
        check_val("rts_high", bus.o_host_rts, 1);
        check_val("rts_not_ready", bus.o_ready, 0);
        d0 = done_cnt;
        bus.i_data  = 8'h33;
        bus.i_valid = 1'b1;
        repeat (30) tick();
        check_val("rts_no_falls", cap_bits.size(), 0);
        check_val("rts_clk_idle", ps2_clk, 1);
        check_val("rts_still_not_ready", bus.o_ready, 0);
        bus.i_valid = 1'b0;
        host_dat_low = 1'b0;
        repeat (5) tick();
        check_val("rts_cleared", bus.o_host_rts, 0);
        check_val("ready_after_rts", bus.o_ready, 1);
        check_val("rts_no_done", done_cnt, d0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_device_tx.md
PS2_DEVICE_TX -- requirements
Module: ps2_device_tx

Interface
REQ-001 i_clk_100k  in  1  system clock, 100 kHz (10 us period); sole clock of the block.
REQ-002 i_rst  in  1  reset; one clock; reset is synchronous and active-high.
REQ-003 i_data  in  8  byte to transmit (scancode or response), sampled on acceptance.
REQ-004 i_valid  in  1  i_data valid; held until accepted.
REQ-005 o_ready  out  1  block can accept a byte this cycle.
REQ-006 o_done  out  1  one-cycle pulse: frame completed, stop bit clocked.
REQ-007 o_abort  out  1  one-cycle pulse: frame aborted by host inhibit; byte retained for retry.
REQ-008 o_host_rts  out  1  level: host request-to-send seen (PS2_CLK high, PS2_DAT low) while IDLE.
REQ-009 PS2_CLK  inout  1  open-drain: driven 0 or released to 'z, never driven 1.
REQ-010 PS2_DAT  inout  1  open-drain: driven 0 or released to 'z, never driven 1.

Function
REQ-011 The block SHALL be a PS/2 device-side transmitter: it SHALL generate PS2_CLK itself and send 11-bit frames: start 0, data LSB first, odd parity, stop 1.
REQ-012 The block SHALL sample PS2_CLK and PS2_DAT through a 2-flop synchronizer each; all line decisions SHALL use the synchronized values.
REQ-013 The states SHALL be IDLE, WAIT_HIGH, SEND, GAP.
REQ-014 o_ready SHALL be 1 only in IDLE with o_host_rts 0; acceptance = i_valid & o_ready at a rising edge; i_data and parity (~^i_data) SHALL be latched then.
REQ-015 IDLE -> WAIT_HIGH on acceptance; WAIT_HIGH -> SEND after 5 consecutive cycles of synced clock high; any low sample SHALL restart that count.
REQ-016 Each SEND bit SHALL last 8 cycles at phase 0..7: phases 0-3 clock released, 4-7 clock driven low (12.5 kHz); bit value SHALL be applied to PS2_DAT from phase 1 and held through phase 7.
REQ-017 Timing with idle bus: accept at edge N; WAIT_HIGH N+1..N+5; SEND bit 0 phase 0 at N+6; start bit driven at N+7; first PS2_CLK low at N+10.
REQ-018 In bits 0-9, at phase 3, a synced clock low (host inhibit) SHALL abort: both lines released next cycle, o_abort pulsed, state -> WAIT_HIGH, byte retained, retransmitted from the start bit.
REQ-019 Inhibit during bit 10 (stop) SHALL be ignored; the frame counts as sent.
REQ-020 After bit 10 phase 7: lines released, o_done pulsed in first GAP cycle, GAP held 8 cycles, then IDLE.
REQ-021 o_host_rts SHALL be 1 in IDLE while synced clock is 1 and synced data is 0, else 0; it SHALL NOT start a frame (host-to-device receive out of scope).
REQ-022 Aborts SHALL retry without limit; i_valid is ignored outside IDLE.
REQ-023 bit counter 4 bits (0..10), phase counter 3 bits (wraps 7->0, bit counter +1), quiet counter 3 bits.

Reset
REQ-024 On i_rst at an edge: state IDLE, counters 0, latched byte cleared, both lines released, o_done=o_abort=o_host_rts=0, o_ready=1 from the next cycle if no RTS.
REQ-025 Reset mid-frame SHALL drop the frame without o_done or o_abort.

Structure
REQ-026 Package ps2_pkg SHALL hold the state enum and constants PHASES_PER_BIT=8, HIGH_PHASES=4, QUIET_CYCLES=5, GAP_CYCLES=8, FRAME_BITS=11.
REQ-027 One sub-module ps2_line_sync (2-flop synchronizer) SHALL be instantiated once for clock and once for data.

Verification
REQ-028 Send 0x1C on idle bus -> device-side sampler sees 0,0,0,1,1,1,0,0,0,0,1 on 11 falling edges; first fall at N+10; o_done once.
REQ-029 Send 0x00 then 0xFF back-to-back -> parity bits 1 and 1; second accept only after GAP (8 cycles); two o_done.
REQ-030 Host pulls PS2_CLK low at bit 5 phase 2 for 20 cycles -> o_abort once, lines released; after 5 high cycles 0xF0 resent in full, o_done once.
REQ-031 PS2_CLK held low before i_valid=1 with 0x5A -> accepted, no clock generated until 5 high cycles; frame 0,0,1,0,1,1,0,1,0,1,1.
REQ-032 i_rst at bit 4 of 0x1C -> lines 'z next cycle, no o_done/o_abort, o_ready=1.
REQ-033 Host holds PS2_DAT low, PS2_CLK high in IDLE -> o_host_rts=1 after sync latency, o_ready=0, no frame starts.
